// File: rtl/spi_flash_pkg.sv
// Shared opcodes, address width and FSM state type for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  localparam int unsigned ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STAT,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizers for CS/SCK/MOSI plus single-cycle SCK rise/fall events.
module spi_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic sck,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall
);

  logic [1:0] cs_ff;
  logic [1:0] sck_ff;
  logic [1:0] mosi_ff;
  logic       sck_q;

  // CS synchronizer resets deasserted so a reset never looks like a selected bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_ff   <= '1;
      sck_ff  <= '0;
      mosi_ff <= '0;
      sck_q   <= 1'b0;
    end else begin
      cs_ff   <= {cs_ff[0], cs_n};
      sck_ff  <= {sck_ff[0], sck};
      mosi_ff <= {mosi_ff[0], mosi};
      sck_q   <= sck_ff[1];
    end
  end

  assign cs_s     = cs_ff[1];
  assign mosi_s   = mosi_ff[1];
  assign sck_rise = sck_ff[1] & ~sck_q;
  assign sck_fall = ~sck_ff[1] & sck_q;

endmodule

// File: rtl/spi_flash_target.sv
// Oversampled SPI mode-0 flash responder serving READ, JEDEC ID and READ STATUS from a loadable byte array.
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4017,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         spi_cs_ni,
  input  logic                         spi_sck_i,
  input  logic                         spi_mosi_i,
  output logic                         spi_miso_o,
  output logic                         spi_miso_oe_o,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_BYTES)-1:0] load_addr_i,
  input  logic [7:0]                   load_data_i,
  output logic                         busy_o,
  output logic                         cmd_err_o
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic          cs_s;
  logic          mosi_s;
  logic          sck_rise;
  logic          sck_fall;

  state_t        state;
  logic [6:0]    cmd_sr;
  logic [AW-1:0] addr;
  logic [4:0]    bit_cnt;
  logic [6:0]    shift;
  logic [1:0]    id_idx;
  logic [7:0]    rd_data;
  logic [7:0]    out_byte;
  logic [7:0]    mem [MEM_BYTES];

  spi_in_sync u_sync (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .cs_n     (spi_cs_ni),
    .sck      (spi_sck_i),
    .mosi     (spi_mosi_i),
    .cs_s     (cs_s),
    .mosi_s   (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // rd_data always tracks mem[addr] one cycle late, which doubles as the prefetch
  always_ff @(posedge clk_i) begin
    if (load_we_i && !busy_o) begin
      mem[load_addr_i] <= load_data_i;
    end
    rd_data <= mem[addr];
  end

  always_comb begin
    out_byte = STATUS_VAL;
    case (state)
      DATA: out_byte = rd_data;
      ID: begin
        case (id_idx)
          2'd0:    out_byte = JEDEC_ID[23:16];
          2'd1:    out_byte = JEDEC_ID[15:8];
          2'd2:    out_byte = JEDEC_ID[7:0];
          default: out_byte = 8'hFF;
        endcase
      end
      default: out_byte = STATUS_VAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cmd_sr        <= '0;
      addr          <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      id_idx        <= '0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      busy_o        <= 1'b0;
      cmd_err_o     <= 1'b0;
    end else begin
      cmd_err_o <= 1'b0;
      busy_o    <= ~cs_s;
      if (cs_s) begin
        state         <= IDLE;
        bit_cnt       <= '0;
        spi_miso_o    <= 1'b0;
        spi_miso_oe_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (sck_rise) begin
            cmd_sr  <= {cmd_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              id_idx  <= '0;
              case ({cmd_sr, mosi_s})
                CMD_READ: state <= ADDR;
                CMD_RDID: begin
                  state         <= ID;
                  spi_miso_oe_o <= 1'b1;
                end
                CMD_RDSR: begin
                  state         <= STAT;
                  spi_miso_oe_o <= 1'b1;
                end
                default: begin
                  state     <= IGNORE;
                  cmd_err_o <= 1'b1;
                end
              endcase
            end
          end
          ADDR: if (sck_rise) begin
            addr    <= {addr[AW-2:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(ADDR_BITS - 1)) begin
              bit_cnt       <= '0;
              state         <= DATA;
              spi_miso_oe_o <= 1'b1;
            end
          end
          DATA, ID, STAT: if (sck_fall) begin
            bit_cnt <= bit_cnt + 5'd1;
            // byte boundary: present the next byte's MSB, keep the rest to shift out
            if (bit_cnt[2:0] == 3'd0) begin
              spi_miso_o <= out_byte[7];
              shift      <= out_byte[6:0];
              if (state == DATA) addr <= addr + 1'b1;
              if (state == ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end else begin
              spi_miso_o <= shift[6];
              shift      <= {shift[5:0], 1'b0};
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_target.sv
// Scoreboard bench: stimulus pushes model-predicted response bytes, a monitor pops them as MISO bytes complete.
module tb_spi_flash_target;

  localparam int unsigned MEM_BYTES = 4096;
  localparam logic [23:0] JEDEC     = 24'hEF4017;
  localparam logic [7:0]  STATUS    = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        load_we = 1'b0;
  logic [11:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        miso;
  logic        oe;
  logic        busy;
  logic        cmd_err;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [7:0]  exp_q [$];
  bit          rx_on = 1'b0;
  int          rx_bits = 0;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  exp_byte;
  bit          oe_low_seen = 1'b0;
  int          err_pulses = 0;
  int          oe_cycles = 0;

  spi_flash_target #(
    .MEM_BYTES  (MEM_BYTES),
    .JEDEC_ID   (JEDEC),
    .STATUS_VAL (STATUS)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .spi_cs_ni     (cs_n),
    .spi_sck_i     (sck),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (oe),
    .load_we_i     (load_we),
    .load_addr_i   (load_addr),
    .load_data_i   (load_data),
    .busy_o        (busy),
    .cmd_err_o     (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
    if (oe) oe_cycles++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] a, input int i);
    if (op == 8'h03) return ref_mem[(int'(a) + i) % MEM_BYTES];
    if (op == 8'h9F) begin
      if (i == 0) return JEDEC[23:16];
      if (i == 1) return JEDEC[15:8];
      if (i == 2) return JEDEC[7:0];
      return 8'hFF;
    end
    return STATUS;
  endfunction

  task automatic load(input int a, input logic [7:0] d);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = 12'(a);
    load_data = d;
    @(negedge clk);
    load_we   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic xbit(input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) xbit(v[b]);
  endtask

  task automatic end_cs();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic txn(input logic [7:0] op, input logic [23:0] a, input int nbytes);
    bit resp;
    resp = (op == 8'h03) || (op == 8'h9F) || (op == 8'h05);
    if (resp) for (int i = 0; i < nbytes; i++) exp_q.push_back(model_byte(op, a, i));
    cs_n = 1'b0;
    xbyte(op);
    if (op == 8'h03) for (int b = 23; b >= 0; b--) xbit(a[b]);
    rx_on = resp;
    for (int i = 0; i < nbytes; i++) xbyte(8'($urandom));
    rx_on = 1'b0;
    end_cs();
  endtask

  // monitor: MISO is sampled where a mode-0 initiator would, on the SCK rising edge
  initial forever begin
    @(posedge sck);
    if (rx_on) begin
      rx_byte = {rx_byte[6:0], miso};
      if (!oe) oe_low_seen = 1'b1;
      rx_bits++;
      if (rx_bits == 8) begin
        rx_bits = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %02h expected none", rx_byte);
        end else begin
          exp_byte = exp_q.pop_front();
          check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_byte});
        end
        check("oe_during_resp", {31'h0, oe_low_seen}, 32'h0);
        oe_low_seen = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [23:0] a;
    int          e0;
    int          o0;
    int          r;

    repeat (3) @(negedge clk);
    check("rst_oe", {31'h0, oe}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_miso", {31'h0, miso}, 32'h0);
    check("reset_oe", {31'h0, oe}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_cmd_err", {31'h0, cmd_err}, 32'h0);

    for (int i = 0; i < int'(MEM_BYTES); i++) load(i, 8'($urandom));
    for (int i = 0; i < 256; i++) load(i, 8'(i));

    txn(8'h03, 24'h000010, 4);

    load(MEM_BYTES - 1, 8'hAA);
    load(0, 8'h55);
    txn(8'h03, 24'h000FFF, 2);
    txn(8'h03, 24'h400FFF, 2);

    txn(8'h9F, 24'h0, 5);
    check("idle_miso_after_id", {31'h0, miso}, 32'h0);
    check("idle_oe_after_id", {31'h0, oe}, 32'h0);
    check("idle_busy_after_id", {31'h0, busy}, 32'h0);
    txn(8'h05, 24'h0, 3);

    e0 = err_pulses;
    o0 = oe_cycles;
    txn(8'hC7, 24'h0, 3);
    check("cmd_err_pulses", 32'(err_pulses - e0), 32'h1);
    check("oe_in_ignore", 32'(oe_cycles - o0), 32'h0);
    txn(8'h03, 24'h000020, 2);

    cs_n = 1'b0;
    xbyte(8'h03);
    for (int b = 23; b >= 11; b--) xbit(1'b0);
    end_cs();
    txn(8'h03, 24'h000020, 1);

    cs_n = 1'b0;
    xbyte(8'h03);
    a = 24'h000030;
    for (int b = 23; b >= 0; b--) xbit(a[b]);
    for (int i = 0; i < 3; i++) xbit(1'b0);
    check("busy_before_rst", {31'h0, busy}, 32'h1);
    check("oe_before_rst", {31'h0, oe}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_miso", {31'h0, miso}, 32'h0);
    check("midrst_oe", {31'h0, oe}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    cs_n = 1'b1;
    sck  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    txn(8'h03, 24'h000030, 2);

    fork
      txn(8'h03, 24'h000020, 1);
      begin
        repeat (100) @(negedge clk);
        load_we   = 1'b1;
        load_addr = 12'h020;
        load_data = ~ref_mem[32];
        @(negedge clk);
        load_we   = 1'b0;
      end
    join
    txn(8'h03, 24'h000020, 1);
    load(32, 8'hC3);
    txn(8'h03, 24'h00001F, 3);

    for (int t = 0; t < 15; t++) begin
      r = int'($urandom_range(0, 9));
      op = (r < 6) ? 8'h03 : (r < 8) ? 8'h9F : 8'h05;
      a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) load(int'($urandom_range(0, MEM_BYTES - 1)), 8'($urandom));
      txn(op, a, int'($urandom_range(1, 5)));
    end

    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    check("total_cmd_err", 32'(err_pulses), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_target.md
Name: spi_flash_target

Overview:
- Synthesizable SPI flash responder: the target end of the serial NOR-flash link that the SoC's SPI flash controller drives as initiator.
- Runs in the system clock domain and oversamples CS/SCK/MOSI. Serves READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05) from an internal byte array.
- Used on FPGA and emulation builds as a boot-image source in place of a physical flash. A side-band load port preloads the array.

Parameters:
- MEM_BYTES, 4096: array depth in bytes; power of two. Addresses wrap modulo MEM_BYTES.
- JEDEC_ID, 24'hEF4017: manufacturer/type/capacity bytes returned by 0x9F, MSB byte first.
- STATUS_VAL, 8'h00: byte returned repeatedly by 0x05 (WIP=0).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- spi_cs_ni  in  1  chip select, active low, asynchronous to clk_i
- spi_sck_i  in  1  SPI clock, mode 0, asynchronous
- spi_mosi_i  in  1  serial data in
- spi_miso_o  out  1  serial data out
- spi_miso_oe_o  out  1  high while target drives MISO
- load_we_i  in  1  array byte write strobe
- load_addr_i  in  $clog2(MEM_BYTES)  array write address
- load_data_i  in  8  array write data
- busy_o  out  1  synchronized CS active
- cmd_err_o  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset: state IDLE, spi_miso_o=0, spi_miso_oe_o=0, busy_o=0, cmd_err_o=0, shift/bit counters 0. Array contents are not reset.
- Input sync: spi_cs_ni, spi_sck_i and spi_mosi_i each pass through a 2-flop synchronizer. The synchronizer flops on spi_cs_ni reset to 1.
- Edge detect: a rising SCK edge is sck_s=1 with sck_q=0; a falling edge is the converse.
- Edge events are seen 3 clk after the pin edge. Each SCK half-period must be ≥4 clk_i periods; a faster SCK is unsupported.
- Mode 0 timing:
  - Sample MOSI on rising events, MSB first.
  - Update spi_miso_o on falling events.
  - Output is valid from 3 clk after the falling SCK pin edge.
- busy_o and spi_miso_oe_o follow synchronized CS; oe stays low in CMD/ADDR/IGNORE.
- States:
  - IDLE: on CS fall → CMD, bit_cnt=0.
  - CMD: after 8 rising events, decode the opcode.
    - 0x03 → ADDR.
    - 0x9F → ID.
    - 0x05 → STAT.
    - Any other opcode → IGNORE, with cmd_err_o pulsed.
  - ADDR: shift 24 bits. On the 24th rising event, issue an array read at addr[$clog2(MEM_BYTES)-1:0]; upper address bits are ignored. → DATA.
  - DATA: on the falling event following a byte boundary, load the shift register with the prefetched byte and drive its MSB. Then issue a prefetch of addr+1, wrapping MEM_BYTES-1 → 0. Continues for an unbounded number of bytes.
  - ID: emit the JEDEC_ID bytes [23:16], [15:8], [7:0], then 8'hFF for every following byte.
  - STAT: emit STATUS_VAL for every byte.
  - IGNORE: MISO not driven; wait for CS high.
- First response bit: driven on the falling event immediately after the last command/address rising event. This is the standard mode-0 flash contract.
- Array: 1-cycle synchronous read.
- Load writes take effect only when busy_o=0. Writes while busy_o=1 are dropped.
- CS high (synchronized) in any state → IDLE within 1 clk. A partial byte is discarded, oe drops and spi_miso_o returns to 0.
- CS glitch shorter than 2 clk: may be missed; no requirement.
- Async reset mid-transaction: immediate IDLE. The next CS fall restarts cleanly.

Decomposition:
- Package spi_flash_pkg holds:
  - opcode constants CMD_READ=8'h03, CMD_RDID=8'h9F, CMD_RDSR=8'h05;
  - the state enum (IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE);
  - ADDR_BITS=24.
- One sub-module, spi_in_sync: three 2-flop synchronizers plus SCK rise/fall pulse generation.

Test Plan:
- Preload bytes 0x00..0xFF at addresses 0..255. Send 03 000010, clock 4 bytes at SCK=clk/8 → MISO returns 10 11 12 13 with no gap and no leading dummy bit.
- Preload addr MEM_BYTES-1=0xAA and 0=0x55. Send 03 000FFF, read 2 bytes → AA 55 (wrap). Repeat with address 0x400FFF → identical result (upper bits ignored).
- Send 9F, read 5 bytes → EF 40 17 FF FF. Send 05, read 3 bytes → 00 00 00.
- Send opcode 0xC7 → cmd_err_o high for exactly 1 cycle, oe stays 0 for the whole transaction. The next 03 transaction reads correctly.
- Start 03 000020, raise CS after 13 address bits, then issue a fresh 03 000020 → the correct byte is returned. Assert rst_ni low mid-DATA → outputs reach reset values immediately.
- Pulse load_we_i with addr 0x20 during an active transaction → byte unchanged on a later read. The same write with CS high → the new value is read back.
